// File: rtl/nibble_pkg.sv
// Shared types and helpers for the nibble packer: output-buffer depth,
// even parity and lane insertion on a word wide enough for any legal packing.
package nibble_pkg;

   localparam int OBUF_DEPTH = 2;
   localparam int MAX_WORD_W = 256;

   typedef logic [MAX_WORD_W-1:0] word_t;

   function automatic logic even_parity(input word_t w);
      return ^w;
   endfunction

   // Replaces bits [lane*lane_w +: lane_w] of word with the low bits of nibble.
   function automatic word_t lane_insert(input word_t       word,
                                         input int unsigned lane,
                                         input int unsigned lane_w,
                                         input word_t       nibble);
      word_t res;
      res = word;
      for (int unsigned i = 0; i < MAX_WORD_W; i++) begin
         if ((i >= lane * lane_w) && (i < (lane + 1) * lane_w)) begin
            res[i] = nibble[i - lane * lane_w];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/nibble_obuf.sv
// Two-entry valid/ready buffer holding {parity, data}; the head entry is held
// stable until popped, and a simultaneous push/pop leaves the occupancy unchanged.
module nibble_obuf
   import nibble_pkg::*;
#(
   parameter int DATA_W = 9
) (
   input  logic              Rd_clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              head_valid,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem_q [OBUF_DEPTH];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'(OBUF_DEPTH)) || do_pop);

   always_ff @(posedge Rd_clk) begin
      if (reset) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_data  = mem_q[rd_ptr_q];
   assign head_valid = (count_q != 2'd0);
   assign count      = count_q;

endmodule

// File: rtl/nibble_packer.sv
// Read-side FIFO stage: pops Width-bit entries, packs NIBBLES of them LSB-first
// into one word and streams words out through a 2-entry valid/ready buffer.
module nibble_packer
   import nibble_pkg::*;
#(
   parameter int Width   = 4,
   parameter int NIBBLES = 2,
   parameter int CNT_W   = 16
) (
   input  logic                       Rd_clk,
   input  logic                       reset,
   input  logic                       Fifo_empty,
   input  logic [Width-1:0]           Fifo_data,
   output logic                       Fifo_rd_en,
   input  logic                       Flush,
   output logic [Width*NIBBLES-1:0]   Out_data,
   output logic                       Out_parity,
   output logic                       Out_valid,
   input  logic                       Out_ready,
   output logic [CNT_W-1:0]           Word_count
);

   localparam int WORD_W = Width * NIBBLES;
   localparam int IDX_W  = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   logic [WORD_W-1:0] asm_q;
   logic [IDX_W-1:0]  rd_idx_q;
   logic [IDX_W-1:0]  cap_idx_q;
   logic              inflight_q;
   logic              flush_pending_q;
   logic [CNT_W-1:0]  word_cnt_q;

   logic              inflight_last;
   logic              credit_ok;
   logic              flush_resolve;
   logic              flush_push;
   logic              obuf_push;
   logic [WORD_W-1:0] cap_word;
   logic [WORD_W-1:0] push_word;
   logic              push_par;
   logic [WORD_W:0]   head;
   logic [1:0]        obuf_count;

   // Credit only counts words that are certain to land; a same-cycle pop is ignored.
   assign inflight_last = inflight_q && (cap_idx_q == LAST_IDX);
   assign credit_ok     = ({1'b0, obuf_count} + {2'b00, inflight_last}) < 3'd2;
   assign Fifo_rd_en    = !reset && !Fifo_empty && !flush_pending_q && credit_ok;

   assign cap_word = WORD_W'(lane_insert(MAX_WORD_W'(asm_q), 32'(cap_idx_q),
                                         Width, MAX_WORD_W'(Fifo_data)));

   // Flush waits for any in-flight read, so it never races a word completion.
   assign flush_resolve = flush_pending_q && !inflight_q && (obuf_count < 2'd2);
   assign flush_push    = flush_resolve && (cap_idx_q != '0);
   assign obuf_push     = inflight_last || flush_push;
   assign push_word     = inflight_last ? cap_word : asm_q;
   assign push_par      = even_parity(MAX_WORD_W'(push_word));

   always_ff @(posedge Rd_clk) begin
      if (reset) begin
         asm_q           <= '0;
         rd_idx_q        <= '0;
         cap_idx_q       <= '0;
         inflight_q      <= 1'b0;
         flush_pending_q <= 1'b0;
         word_cnt_q      <= '0;
      end else begin
         inflight_q <= Fifo_rd_en;
         if (Fifo_rd_en) begin
            rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
         end
         if (inflight_q) begin
            if (inflight_last) begin
               asm_q     <= '0;
               cap_idx_q <= '0;
            end else begin
               asm_q     <= cap_word;
               cap_idx_q <= cap_idx_q + 1'b1;
            end
         end
         if (flush_resolve) begin
            flush_pending_q <= 1'b0;
            if (flush_push) begin
               asm_q     <= '0;
               cap_idx_q <= '0;
               rd_idx_q  <= '0;
            end
         end else if (Flush) begin
            flush_pending_q <= 1'b1;
         end
         if (Out_valid && Out_ready) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
         end
      end
   end

   nibble_obuf #(
      .DATA_W (WORD_W + 1)
   ) u_obuf (
      .Rd_clk     (Rd_clk),
      .reset      (reset),
      .push       (obuf_push),
      .push_data  ({push_par, push_word}),
      .pop        (Out_ready),
      .head_data  (head),
      .head_valid (Out_valid),
      .count      (obuf_count)
   );

   assign Out_data   = head[WORD_W-1:0];
   assign Out_parity = head[WORD_W];
   assign Word_count = word_cnt_q;

endmodule
